// File: rtl/maze_render_pkg.sv
// Shared defaults, fixed ceiling/floor colors and state encodings for the
// column-based maze renderer.
package maze_render_pkg;

  localparam int unsigned SCREEN_H_DEF   = 120;
  localparam int unsigned NUM_COLS_DEF   = 40;
  localparam int unsigned COL_STRIDE_DEF = 4;

  localparam logic [2:0] CEIL_COLOR  = 3'b001;
  localparam logic [2:0] FLOOR_COLOR = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_CALC      = 3'd2,
    S_SEG_START = 3'd3,
    S_SEG_WAIT  = 3'd4,
    S_GAP       = 3'd5,
    S_DONE      = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    SEG_CEIL  = 2'd0,
    SEG_WALL  = 2'd1,
    SEG_FLOOR = 2'd2
  } seg_e;

endpackage

// File: rtl/column_segment_calc.sv
// Splits one screen column into ceiling / wall / floor rectangles from a raw
// wall height; the height is clamped so the three sizes always sum to SCREEN_H.
module column_segment_calc
  import maze_render_pkg::*;
#(
  parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
  input  logic [6:0] height_i,
  output logic [6:0] ceil_size_o,
  output logic [6:0] wall_y_o,
  output logic [6:0] wall_size_o,
  output logic [6:0] floor_y_o,
  output logic [6:0] floor_size_o
);

  localparam logic [6:0] SCREEN_H_W = 7'(SCREEN_H);

  logic [6:0] h_clamped;
  logic [6:0] ceil_size;

  always_comb begin
    h_clamped = (height_i > SCREEN_H_W) ? SCREEN_H_W : height_i;
    // odd leftovers go to the floor, so the wall sits one row high of centre
    ceil_size = (SCREEN_H_W - h_clamped) >> 1;
  end

  assign ceil_size_o  = ceil_size;
  assign wall_y_o     = ceil_size;
  assign wall_size_o  = h_clamped;
  assign floor_y_o    = ceil_size + h_clamped;
  assign floor_size_o = SCREEN_H_W - ceil_size - h_clamped;

endmodule

// File: rtl/column_render_sequencer.sv
// Walks every screen column, fetches its wall data and issues up to three
// rectangle draws (ceiling, wall, floor) to a downstream drawer.
module column_render_sequencer
  import maze_render_pkg::*;
#(
  parameter int unsigned NUM_COLS   = NUM_COLS_DEF,
  parameter int unsigned COL_STRIDE = COL_STRIDE_DEF,
  parameter int unsigned SCREEN_H   = SCREEN_H_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start_frame,
  output logic       col_req,
  output logic [5:0] col_index,
  input  logic       col_valid,
  input  logic [6:0] wall_height_in,
  input  logic [2:0] wall_color_in,
  output logic [7:0] X_pos_out,
  output logic [6:0] Y_pos_out,
  output logic [6:0] rect_size,
  output logic [2:0] color_out,
  output logic       start_plot,
  input  logic       end_plot,
  output logic       busy,
  output logic       frame_done
);

  state_e     state_q, state_d;
  seg_e       seg_q, seg_d;
  logic [5:0] col_q, col_d;
  logic [6:0] height_q, height_d;
  logic [2:0] wcolor_q, wcolor_d;
  logic       req_first_q, req_first_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [6:0] size_q, size_d;
  logic [2:0] pcolor_q, pcolor_d;
  logic       start_plot_q, start_plot_d;

  logic [6:0] ceil_size, wall_y, wall_size, floor_y, floor_size;
  logic [6:0] cur_y, cur_size;
  logic [2:0] cur_color;
  logic       last_col;
  state_e     adv_state;
  seg_e       adv_seg;
  logic [5:0] adv_col;
  logic       adv_req_first;

  column_segment_calc #(
    .SCREEN_H(SCREEN_H)
  ) u_calc (
    .height_i    (height_q),
    .ceil_size_o (ceil_size),
    .wall_y_o    (wall_y),
    .wall_size_o (wall_size),
    .floor_y_o   (floor_y),
    .floor_size_o(floor_size)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      seg_q        <= SEG_CEIL;
      col_q        <= '0;
      height_q     <= '0;
      wcolor_q     <= '0;
      req_first_q  <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      size_q       <= '0;
      pcolor_q     <= '0;
      start_plot_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      seg_q        <= seg_d;
      col_q        <= col_d;
      height_q     <= height_d;
      wcolor_q     <= wcolor_d;
      req_first_q  <= req_first_d;
      x_q          <= x_d;
      y_q          <= y_d;
      size_q       <= size_d;
      pcolor_q     <= pcolor_d;
      start_plot_q <= start_plot_d;
    end
  end

  always_comb begin
    cur_y     = '0;
    cur_size  = ceil_size;
    cur_color = CEIL_COLOR;
    case (seg_q)
      SEG_WALL: begin
        cur_y     = wall_y;
        cur_size  = wall_size;
        cur_color = wcolor_q;
      end
      SEG_FLOOR: begin
        cur_y     = floor_y;
        cur_size  = floor_size;
        cur_color = FLOOR_COLOR;
      end
      default: ;
    endcase
  end

  // Where to go once the current segment is finished or skipped.
  assign last_col = (col_q == 6'(NUM_COLS - 1));

  always_comb begin
    adv_state     = S_SEG_START;
    adv_seg       = seg_q;
    adv_col       = col_q;
    adv_req_first = 1'b0;
    if (seg_q != SEG_FLOOR) begin
      adv_seg = seg_e'(seg_q + 2'd1);
    end else if (last_col) begin
      adv_state = S_DONE;
    end else begin
      adv_state     = S_REQ;
      adv_col       = col_q + 6'd1;
      adv_req_first = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    seg_d        = seg_q;
    col_d        = col_q;
    height_d     = height_q;
    wcolor_d     = wcolor_q;
    req_first_d  = 1'b0;
    x_d          = x_q;
    y_d          = y_q;
    size_d       = size_q;
    pcolor_d     = pcolor_q;
    start_plot_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_frame) begin
          col_d       = '0;
          state_d     = S_REQ;
          req_first_d = 1'b1;
        end
      end
      S_REQ: begin
        if (col_valid) begin
          height_d = wall_height_in;
          wcolor_d = wall_color_in;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        seg_d   = SEG_CEIL;
        state_d = S_SEG_START;
      end
      S_SEG_START: begin
        if (cur_size == '0) begin
          state_d     = adv_state;
          seg_d       = adv_seg;
          col_d       = adv_col;
          req_first_d = adv_req_first;
        end else begin
          x_d          = 8'(32'(col_q) * COL_STRIDE);
          y_d          = cur_y;
          size_d       = cur_size;
          pcolor_d     = cur_color;
          start_plot_d = 1'b1;
          state_d      = S_SEG_WAIT;
        end
      end
      S_SEG_WAIT: begin
        if (end_plot) state_d = S_GAP;
      end
      S_GAP: begin
        state_d     = adv_state;
        seg_d       = adv_seg;
        col_d       = adv_col;
        req_first_d = adv_req_first;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    col_req    = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: busy = 1'b0;
      S_REQ:  col_req = req_first_q;
      S_DONE: begin
        busy       = 1'b0;
        frame_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign col_index  = col_q;
  assign X_pos_out  = x_q;
  assign Y_pos_out  = y_q;
  assign rect_size  = size_q;
  assign color_out  = pcolor_q;
  assign start_plot = start_plot_q;

endmodule
